// File: rtl/track_collision_scheduler.sv
// track_collision_scheduler: sweeps every (car, segment) pair through one shared
// collision checker per frame and publishes per-car collision/off-track summaries.
module track_collision_scheduler #(
    parameter int NUM_CARS      = 2,
    parameter int NUM_SEGMENTS  = 8,
    parameter int SEG_IDX_WIDTH = 3,
    parameter int CAR_IDX_WIDTH = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [SEG_IDX_WIDTH:0]            i_seg_count,
    output logic                              o_issue_valid,
    output logic [CAR_IDX_WIDTH-1:0]          o_car_sel,
    output logic [SEG_IDX_WIDTH-1:0]          o_seg_idx,
    input  logic                              i_chk_in_region,
    input  logic                              i_chk_collision,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [NUM_CARS-1:0]               o_collision,
    output logic [NUM_CARS*SEG_IDX_WIDTH-1:0] o_hit_seg,
    output logic [NUM_CARS-1:0]               o_off_track
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [SEG_IDX_WIDTH:0] s_cnt, s_clamp;
    logic [CAR_IDX_WIDTH-1:0] car, d_car;
    logic [SEG_IDX_WIDTH-1:0] seg, d_seg;
    logic d_valid, accept, last_seg, last_issue;
    logic [NUM_CARS-1:0] region_any, collided, region_nxt, collided_nxt;
    logic [NUM_CARS*SEG_IDX_WIDTH-1:0] hit, hit_nxt;

    assign s_clamp = i_seg_count > (SEG_IDX_WIDTH+1)'(NUM_SEGMENTS) ? (SEG_IDX_WIDTH+1)'(NUM_SEGMENTS) : i_seg_count;
    assign accept = state == IDLE && i_start;
    assign last_seg = {1'b0, seg} == s_cnt - (SEG_IDX_WIDTH+1)'(1);
    assign last_issue = last_seg && car == CAR_IDX_WIDTH'(NUM_CARS - 1);
    assign o_issue_valid = state == SCAN;
    assign o_busy = state == SCAN || state == DRAIN;
    assign o_done = state == DONE;
    assign o_car_sel = car;
    assign o_seg_idx = seg;

    always_comb begin
        state_nxt = state == IDLE  ? (accept ? (s_clamp == '0 ? DONE : SCAN) : IDLE) :
                    state == SCAN  ? (last_issue ? DRAIN : SCAN) :
                    state == DRAIN ? DONE : IDLE;
    end

    // Segments are scanned in ascending order, so the first collision seen is the lowest index.
    always_comb begin
        region_nxt   = region_any;
        collided_nxt = collided;
        hit_nxt      = hit;
        if (accept) begin
            region_nxt   = '0;
            collided_nxt = '0;
            hit_nxt      = '0;
        end else if (d_valid) begin
            for (int c = 0; c < NUM_CARS; c++) begin
                if (d_car == CAR_IDX_WIDTH'(c)) begin
                    region_nxt[c] = region_any[c] | i_chk_in_region;
                    if (i_chk_collision && !collided[c]) begin
                        collided_nxt[c] = 1'b1;
                        hit_nxt[c*SEG_IDX_WIDTH +: SEG_IDX_WIDTH] = d_seg;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            s_cnt       <= '0;
            car         <= '0;
            seg         <= '0;
            d_valid     <= 1'b0;
            d_car       <= '0;
            d_seg       <= '0;
            region_any  <= '0;
            collided    <= '0;
            hit         <= '0;
            o_collision <= '0;
            o_hit_seg   <= '0;
            o_off_track <= '0;
        end else begin
            state      <= state_nxt;
            d_valid    <= state == SCAN;
            d_car      <= car;
            d_seg      <= seg;
            region_any <= region_nxt;
            collided   <= collided_nxt;
            hit        <= hit_nxt;
            if (accept) begin
                s_cnt <= s_clamp;
                car   <= '0;
                seg   <= '0;
            end else if (state == SCAN) begin
                seg <= last_seg ? '0 : seg + 1'b1;
                car <= last_issue ? '0 : last_seg ? car + 1'b1 : car;
            end
            if (state_nxt == DONE) begin
                o_collision <= collided_nxt;
                o_hit_seg   <= hit_nxt;
                o_off_track <= ~region_nxt;
            end
        end
    end
endmodule

// File: tb/tb_track_collision_scheduler.sv
// tb_track_collision_scheduler: directed frames with a scoreboard of expected issues
// and summaries, checked by a monitor whenever the DUT issues a pair or pulses o_done.
module tb_track_collision_scheduler;
    logic clk = 0, i_rst_n = 0, i_start = 0;
    logic [3:0] i_seg_count = 0;
    logic i_chk_in_region = 0, i_chk_collision = 0;
    logic o_issue_valid, o_busy, o_done;
    logic [0:0] o_car_sel;
    logic [2:0] o_seg_idx;
    logic [1:0] o_collision, o_off_track;
    logic [5:0] o_hit_seg;

    track_collision_scheduler dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_seg_count(i_seg_count),
        .o_issue_valid(o_issue_valid), .o_car_sel(o_car_sel), .o_seg_idx(o_seg_idx),
        .i_chk_in_region(i_chk_in_region), .i_chk_collision(i_chk_collision),
        .o_busy(o_busy), .o_done(o_done), .o_collision(o_collision),
        .o_hit_seg(o_hit_seg), .o_off_track(o_off_track)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] col;
        logic [5:0] hit;
        logic [1:0] off;
        int         cyc;
    } sum_t;

    sum_t dq[$];
    logic [3:0] iq[$];
    logic [7:0] reg_mask [2];
    logic [7:0] col_mask [2];
    logic [9:0] pub = '0;
    int tests = 0, fails = 0, cyc = 0;
    logic mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Checker model: answers one cycle after each issue; drives ones when nothing was issued.
    initial forever begin
        logic r, c;
        logic [7:0] rm, cm;
        @(negedge clk);
        rm = reg_mask[o_car_sel];
        cm = col_mask[o_car_sel];
        r = o_issue_valid ? rm[o_seg_idx] : 1'b1;
        c = o_issue_valid ? cm[o_seg_idx] : 1'b1;
        @(posedge clk);
        #1;
        i_chk_in_region = r;
        i_chk_collision = c;
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (o_issue_valid) begin
                if (iq.size() == 0) chk("unexpected_issue", {o_car_sel, o_seg_idx}, 32'hFF);
                else chk("issue_pair", {o_car_sel, o_seg_idx}, iq.pop_front());
            end
            if (o_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    sum_t e;
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("collision", o_collision, e.col);
                    chk("hit_seg", o_hit_seg, e.hit);
                    chk("off_track", o_off_track, e.off);
                    pub = {e.col, e.hit, e.off};
                end
            end else
                chk("summary_hold", {o_collision, o_hit_seg, o_off_track}, pub);
        end
    end

    task automatic set_masks(input logic [7:0] r0, input logic [7:0] c0, input logic [7:0] r1, input logic [7:0] c1);
        reg_mask[0] = r0; col_mask[0] = c0;
        reg_mask[1] = r1; col_mask[1] = c1;
    endtask

    task automatic start_frame(input logic [3:0] n, input logic [1:0] col, input logic [5:0] hit,
                               input logic [1:0] off, output int t0);
        int s;
        s = n > 8 ? 8 : int'(n);
        @(negedge clk);
        i_start = 1;
        i_seg_count = n;
        t0 = cyc;
        for (int c = 0; c < 2; c++)
            for (int g = 0; g < s; g++) iq.push_back({c[0], g[2:0]});
        dq.push_back('{col, hit, off, t0 + (s == 0 ? 1 : 2 * s + 2)});
        @(negedge clk);
        i_start = 0;
        i_seg_count = 4'd9;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && dq.size() != 0; i++) @(posedge clk);
        if (dq.size() != 0) begin
            chk("done_timeout", dq.size(), 0);
            dq.delete();
        end
        @(negedge clk);
        chk("issues_drained", iq.size(), 0);
        iq.delete();
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 60 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 0;
        i_rst_n = 0;
        @(posedge clk);
        #1;
        iq.delete();
        dq.delete();
        pub = '0;
        chk("rst_issue_valid", o_issue_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_sel", {o_car_sel, o_seg_idx}, 0);
        chk("rst_summary", {o_collision, o_hit_seg, o_off_track}, 0);
        @(negedge clk);
        i_rst_n = 1;
        mon_en = 1;
    endtask

    initial begin
        int t0;
        set_masks(8'h00, 8'h00, 8'h00, 8'h00);
        do_reset();
        repeat (2) @(negedge clk);

        start_frame(4'd8, 2'b00, 6'h00, 2'b11, t0);
        wait_until(t0 + 5);
        chk("busy_mid_scan", o_busy, 1);
        wait_done();

        set_masks(8'h00, 8'h00, 8'h20, 8'h24);
        start_frame(4'd8, 2'b10, 6'h10, 2'b01, t0);
        wait_done();

        set_masks(8'h81, 8'h00, 8'h00, 8'h00);
        start_frame(4'd8, 2'b00, 6'h00, 2'b10, t0);
        wait_done();

        set_masks(8'h10, 8'h12, 8'h04, 8'h04);
        start_frame(4'd3, 2'b11, 6'h11, 2'b01, t0);
        wait_done();

        start_frame(4'd0, 2'b00, 6'h00, 2'b11, t0);
        wait_done();

        set_masks(8'h00, 8'h06, 8'h80, 8'h80);
        start_frame(4'd12, 2'b11, 6'h39, 2'b01, t0);
        wait_done();

        set_masks(8'h02, 8'h00, 8'h00, 8'h01);
        start_frame(4'd2, 2'b10, 6'h00, 2'b10, t0);
        i_start = 1;
        i_seg_count = 4'd5;
        @(negedge clk);
        i_start = 0;
        wait_until(t0 + 6);
        chk("done_cycle_for_pulse", o_done, 1);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("idle_after_ignored_start", o_busy, 0);

        set_masks(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start_frame(4'd8, 2'b11, 6'h00, 2'b00, t0);
        wait_until(t0 + 4);
        do_reset();
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", {o_collision, o_hit_seg, o_off_track}, 0);

        set_masks(8'h08, 8'h08, 8'h00, 8'h00);
        start_frame(4'd8, 2'b01, 6'h03, 2'b10, t0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/track_collision_scheduler.md
# track_collision_scheduler

Time-multiplexes one shared track-collision checker (horizontal, vertical or circle segment datapath, muxed by segment type outside this block) across every (car, track segment) pair once per game frame. It sits between the frame-tick logic and physics update. It issues pair indices to the track-segment table and checker, and collects the checker's in-region and collision flags. It then publishes per-car frame summaries: any collision, first colliding segment, and off-track.

## Interface
Parameters:
- NUM_CARS, 2, number of cars scanned per frame (1..4)
- NUM_SEGMENTS, 8, depth of track-segment table (2..16)
- SEG_IDX_WIDTH, 3, width of segment index, equal to clog2(NUM_SEGMENTS)
- CAR_IDX_WIDTH, 1, width of car index, max(1, clog2(NUM_CARS))

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  frame-start pulse; accepted only in IDLE
- i_seg_count  in  SEG_IDX_WIDTH+1  active segments this frame; sampled at start accept; values above NUM_SEGMENTS clamp to NUM_SEGMENTS
- o_issue_valid  out  1  pair on o_car_sel/o_seg_idx is valid this cycle
- o_car_sel  out  CAR_IDX_WIDTH  car whose position/velocity/radius feed the checker
- o_seg_idx  out  SEG_IDX_WIDTH  segment-table read address (table has 1-cycle registered read)
- i_chk_in_region  in  1  checker in-region flag for the pair issued previous cycle
- i_chk_collision  in  1  checker collision flag for the pair issued previous cycle
- o_busy  out  1  high in SCAN and DRAIN
- o_done  out  1  one-cycle pulse; summaries updated and stable
- o_collision  out  NUM_CARS  bit c: car c collided with any active segment this frame
- o_hit_seg  out  NUM_CARS*SEG_IDX_WIDTH  field c: lowest colliding segment index of car c; 0 when bit c of o_collision is 0
- o_off_track  out  NUM_CARS  bit c: car c in region of no active segment

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: i_start=1 → latch clamped count S, clear accumulators, car=0, seg=0, go to SCAN. If S=0, go directly to DONE with o_off_track all ones and o_collision all zeros.
- SCAN: o_issue_valid=1 every cycle. Order is car-major: car0 seg0..S-1, then car1 seg0..S-1, and so on. After the issue of (NUM_CARS-1, S-1), go to DRAIN.
- DRAIN: o_issue_valid=0. The result of the last issue is captured. Go to DONE.
- DONE: publish summaries, o_done=1 for this cycle only, go to IDLE.
- Capture: a one-cycle-delayed copy of (issue_valid, car, seg) qualifies i_chk_*.
  - Per car, region_any |= in_region.
  - On the first collision, set collided and store seg. Later collisions of that car do not overwrite the stored seg.
- o_collision, o_hit_seg and o_off_track (= ~region_any) are registered at DONE. They hold until the next DONE, are not altered during SCAN, and i_start does not clear them.
- i_start while not IDLE: ignored, no queuing.
- i_seg_count changes after accept: ignored until the next accept.
- Checker flags outside a delayed-valid cycle: ignored.

## Timing
- Reset (i_rst_n=0 at rising edge): state IDLE; o_issue_valid, o_busy, o_done = 0; o_car_sel, o_seg_idx = 0; o_collision = 0; o_hit_seg = 0; o_off_track = 0; accumulators cleared.
- Reset during SCAN/DRAIN aborts the scan. No o_done is produced, and outputs take their reset values.
- i_start accepted at edge of cycle T. Issues occupy cycles T+1 .. T+NUM_CARS*S.
- DRAIN is at T+NUM_CARS*S+1. o_done is at T+NUM_CARS*S+2. Default parameters with S=8 give o_done at T+18.
- An i_start coincident with the o_done cycle is ignored. The earliest next accept is the cycle after o_done.
- o_busy is high from T+1 through the DRAIN cycle.
- i_chk_* must be valid in the cycle after the corresponding issue: one-cycle table read, combinational checker.

## Test plan
- Reset, then i_start with S=8 and flags all 0 → 16 issues (car0 seg0..7, car1 seg0..7), o_done at T+18, o_collision=00, o_off_track=11.
- Car1 in_region on seg5 only; collision on seg5 and seg2 → o_collision=10, car1 hit_seg=2, o_off_track=01.
- Car0 in_region on seg0 and seg7 with no collisions → o_collision=00, o_off_track=10.
- i_seg_count=3 → 6 issues, seg_idx never exceeds 2, o_done at T+8. i_seg_count=0 → o_done at T+1 with no issues and o_off_track=11. i_seg_count=12 → clamped to 8.
- i_start pulsed during SCAN and on the o_done cycle → no effect. Previous summaries remain unchanged during the next scan until its o_done.
- i_rst_n low at T+5 mid-scan → IDLE, all outputs 0, no o_done. A fresh i_start then completes normally.
